rsa: RTL and testbench

Modular exponentiation core that computes C = M^E mod N with Montgomery arithmetic. It is the arithmetic engine of the RSA datapath. The caller supplies the precomputed constants N_INV = −N⁻¹ mod 2^WIDTH and R2_MOD_N = R² mod N, where R = 2^WIDTH. The core runs one exponentiation per start pulse and reports completion with a done pulse.

---
 rtl/rsa_pkg.sv | 16 +
 rtl/rsa_mont_mul.sv | 29 ++
 rtl/rsa.sv | 123 ++++++++++++
 tb/tb_rsa.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the Montgomery modular exponentiation core.
// Holds the FSM state encoding and the default operand width.
package rsa_pkg;

   localparam int DEFAULT_WIDTH = 64;

   typedef enum logic [2:0] {
      IDLE,
      PRE_M,
      PRE_X,
      SQR,
      MUL,
      POST
   } state_t;

endpackage

// File: rtl/rsa_mont_mul.sv
// Combinational Montgomery product result = a*b*R^-1 mod n (REDC, R = 2^WIDTH).
// Zero latency, no flow control; needs a < 2^WIDTH and b < n so one final subtraction suffices.
module mont_mul #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   input  logic [WIDTH-1:0] n_inv,
   output logic [WIDTH-1:0] result
);

   logic [2*WIDTH-1:0] t_full;
   logic [WIDTH-1:0]   m;
   logic [2*WIDTH-1:0] mn;
   logic [WIDTH:0]     t;
   logic [WIDTH:0]     t_sub;

   always_comb begin
      t_full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      m      = t_full[WIDTH-1:0] * n_inv;
      mn     = {{WIDTH{1'b0}}, m} * {{WIDTH{1'b0}}, n};
      // The low WIDTH bits of the sum are zero by construction of m, so only the top half matters.
      t      = (WIDTH+1)'(({1'b0, t_full} + {1'b0, mn}) >> WIDTH);
      t_sub  = t - {1'b0, n};
      result = (t >= {1'b0, n}) ? t_sub[WIDTH-1:0] : t[WIDTH-1:0];
   end

endmodule

// File: rtl/rsa.sv
// C = M^E mod N via left-to-right square-and-multiply on one shared Montgomery multiplier.
// Latency 3 + E_BITS + popcount(E) cycles from start; start is ignored while busy or while done is high.
module rsa
   import rsa_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int E_BITS = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDTH-1:0]  M,
   input  logic [E_BITS-1:0] E,
   input  logic [WIDTH-1:0]  N,
   input  logic [WIDTH-1:0]  N_INV,
   input  logic [WIDTH-1:0]  R2_MOD_N,
   output logic [WIDTH-1:0]  C,
   output logic              done
);

   localparam int IW = (E_BITS > 1) ? $clog2(E_BITS) : 1;

   state_t            state;
   logic [WIDTH-1:0]  m_reg;
   logic [E_BITS-1:0] e_reg;
   logic [WIDTH-1:0]  n_reg;
   logic [WIDTH-1:0]  n_inv_reg;
   logic [WIDTH-1:0]  r2_reg;
   logic [WIDTH-1:0]  x_reg;
   logic [WIDTH-1:0]  mbar_reg;
   logic [IW-1:0]     idx;

   logic [WIDTH-1:0]  op_a;
   logic [WIDTH-1:0]  op_b;
   logic [WIDTH-1:0]  mm;

   // Every b operand is already < N, which keeps the single-subtraction REDC valid even for M >= N.
   always_comb begin
      op_a = '0;
      op_b = '0;
      unique case (state)
         PRE_M: begin op_a = m_reg;        op_b = r2_reg;        end
         PRE_X: begin op_a = WIDTH'(1);    op_b = r2_reg;        end
         SQR:   begin op_a = x_reg;        op_b = x_reg;         end
         MUL:   begin op_a = x_reg;        op_b = mbar_reg;      end
         POST:  begin op_a = x_reg;        op_b = WIDTH'(1);     end
         default: begin op_a = '0;         op_b = '0;            end
      endcase
   end

   mont_mul #(.WIDTH(WIDTH)) u_mont_mul (
      .a      (op_a),
      .b      (op_b),
      .n      (n_reg),
      .n_inv  (n_inv_reg),
      .result (mm)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         m_reg     <= '0;
         e_reg     <= '0;
         n_reg     <= '0;
         n_inv_reg <= '0;
         r2_reg    <= '0;
         x_reg     <= '0;
         mbar_reg  <= '0;
         idx       <= '0;
         C         <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && !done) begin
                  m_reg     <= M;
                  e_reg     <= E;
                  n_reg     <= N;
                  n_inv_reg <= N_INV;
                  r2_reg    <= R2_MOD_N;
                  state     <= PRE_M;
               end
            end
            PRE_M: begin
               mbar_reg <= mm;
               state    <= PRE_X;
            end
            PRE_X: begin
               x_reg <= mm;
               idx   <= IW'(E_BITS - 1);
               state <= SQR;
            end
            SQR: begin
               x_reg <= mm;
               if (e_reg[idx]) begin
                  state <= MUL;
               end else if (idx == '0) begin
                  state <= POST;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            MUL: begin
               x_reg <= mm;
               if (idx == '0) begin
                  state <= POST;
               end else begin
                  idx   <= idx - 1'b1;
                  state <= SQR;
               end
            end
            POST: begin
               C     <= mm;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa.sv
// Self-checking bench for rsa: directed vectors plus random operands against a plain-arithmetic modexp model.
module tb_rsa;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [63:0] M = '0;
   logic [63:0] E = '0;
   logic [63:0] N = '0;
   logic [63:0] N_INV = '0;
   logic [63:0] R2_MOD_N = '0;
   logic [63:0] C;
   logic        done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   rsa #(.WIDTH(64), .E_BITS(64)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .M        (M),
      .E        (E),
      .N        (N),
      .N_INV    (N_INV),
      .R2_MOD_N (R2_MOD_N),
      .C        (C),
      .done     (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: ordinary square-and-multiply with full-width products, no Montgomery form.
   function automatic logic [63:0] modexp(input logic [63:0] m, input logic [63:0] e,
                                          input logic [63:0] n);
      logic [127:0] r;
      logic [127:0] b;
      logic [127:0] nn;
      nn = {64'd0, n};
      r  = 128'd1 % nn;
      b  = {64'd0, m} % nn;
      for (int i = 63; i >= 0; i--) begin
         r = (r * r) % nn;
         if (e[i]) r = (r * b) % nn;
      end
      return r[63:0];
   endfunction

   function automatic logic [63:0] neg_inv(input logic [63:0] n);
      logic [63:0] x;
      x = n;
      for (int i = 0; i < 6; i++) x = x * (64'd2 - n * x);
      return -x;
   endfunction

   function automatic logic [63:0] r2_of(input logic [63:0] n);
      logic [128:0] p;
      logic [127:0] q;
      logic [63:0]  r;
      p = 129'd1 << 64;
      r = 64'(p % {65'd0, n});
      q = ({64'd0, r} * {64'd0, r}) % {64'd0, n};
      return q[63:0];
   endfunction

   task automatic run_op(input logic [63:0] m, input logic [63:0] e, input logic [63:0] n,
                         input logic [63:0] ninv, input logic [63:0] r2,
                         input bit disturb, input string tag);
      logic [63:0] exp_c;
      int lat;
      int exp_lat;
      int base;
      exp_c   = modexp(m, e, n);
      exp_lat = 3 + 64 + $countones(e);
      @(negedge clk);
      M = m; E = e; N = n; N_INV = ninv; R2_MOD_N = r2;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      base = done_cnt;
      if (disturb) begin
         M = ~m; E = e ^ 64'hFF; N = n + 64'd2; N_INV = ~ninv; R2_MOD_N = r2 + 64'd1;
      end
      lat = 0;
      while (lat < 300) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) break;
         if (disturb && lat == 20) start = 1'b1;
         if (disturb && lat == 21) start = 1'b0;
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_c"}, C, exp_c);
      if (disturb) start = 1'b1;   // lands in the cycle done is high, must be ignored
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_done_width"}, {63'd0, done}, 64'd0);
      if (disturb) begin
         repeat (100) @(posedge clk);
         #1;
         check({tag, "_done_count"}, 64'(done_cnt - base), 64'd1);
         check({tag, "_c_hold"}, C, exp_c);
      end
   endtask

   localparam logic [63:0] BASIC_M    = 64'h6E6861746E686174;
   localparam logic [63:0] BASIC_NINV = 64'd15092790605762360413;

   initial begin
      logic [63:0] rn, rm, re;
      int base;
      int lat;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_c", C, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);

      run_op(BASIC_M, 64'd4, 64'd11, BASIC_NINV, 64'd3, 1'b0, "basic");
      check("basic_fixed_c", C, 64'd9);
      run_op(BASIC_M, 64'd1, 64'd11, BASIC_NINV, 64'd3, 1'b0, "e1");
      check("e1_fixed_c", C, 64'd5);
      run_op(BASIC_M, 64'd0, 64'd11, BASIC_NINV, 64'd3, 1'b0, "e0");
      check("e0_fixed_c", C, 64'd1);
      run_op(64'd65, 64'd17, 64'd3233, neg_inv(64'd3233), r2_of(64'd3233), 1'b0, "rsa_enc");
      check("rsa_enc_fixed_c", C, 64'd2790);
      run_op(64'd2790, 64'd413, 64'd3233, neg_inv(64'd3233), r2_of(64'd3233), 1'b0, "rsa_dec");
      check("rsa_dec_fixed_c", C, 64'd65);

      run_op(BASIC_M, 64'd4, 64'd11, BASIC_NINV, 64'd3, 1'b1, "disturb");
      check("disturb_fixed_c", C, 64'd9);

      // Abort a run while it is squaring; no done may follow and C must clear.
      @(negedge clk);
      M = BASIC_M; E = 64'd4; N = 64'd11; N_INV = BASIC_NINV; R2_MOD_N = 64'd3;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      base = done_cnt;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_cnt - base), 64'd0);
      check("abort_c", C, 64'd0);
      run_op(BASIC_M, 64'd4, 64'd11, BASIC_NINV, 64'd3, 1'b0, "after_abort");

      for (int i = 0; i < 8; i++) begin
         rn = {$urandom, $urandom} | 64'd1;
         if (rn == 64'd1) rn = 64'd3;
         if (i == 0) rn = rn | 64'h8000_0000_0000_0000;
         rm = {$urandom, $urandom};
         re = {$urandom, $urandom};
         if (i == 1) re = 64'hFFFF_FFFF_FFFF_FFFF;
         run_op(rm, re, rn, neg_inv(rn), r2_of(rn), 1'b0, $sformatf("rand%0d", i));
      end

      lat = done_cnt;
      check("total_dones", 64'(lat), 64'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
